lcd_init_seq: RTL

// Init sequencer for the 8080-style 8-bit LCD bus: pulses hardware reset, then walks the init ROM (9-bit {DCX,DATA} words) from address 0 to ROM_LAST.

---
 rtl/lcd_init_seq.sv | 121 ++++++++++++
 1 files changed

// File: rtl/lcd_init_seq.sv
// Power-up sequencer for an 8080-style 8-bit LCD: pulses hardware reset, then streams
// the init ROM to the panel one write strobe per word, pausing after sleep-out (0x11).
module lcd_init_seq #(
  parameter int ROM_LAST   = 103,
  parameter int T_RST_LO   = 500,
  parameter int T_RST_WAIT = 6_000_000,
  parameter int T_SLP      = 6_000_000,
  parameter int T_WR_LO    = 2,
  parameter int T_WR_HI    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [6:0] rom_addr,
  input  logic [8:0] rom_data,
  output logic       lcd_rst_n,
  output logic       lcd_cs_n,
  output logic       lcd_dcx,
  output logic       lcd_wr_n,
  output logic       lcd_rd_n,
  output logic [7:0] lcd_db,
  output logic       busy,
  output logic       done
);

  localparam int T_MAX_A = (T_RST_WAIT > T_SLP) ? T_RST_WAIT : T_SLP;
  localparam int T_MAX_B = (T_RST_LO > T_WR_LO) ? T_RST_LO : T_WR_LO;
  localparam int T_MAX_C = (T_MAX_B > T_WR_HI) ? T_MAX_B : T_WR_HI;
  localparam int T_MAX   = (T_MAX_A > T_MAX_C) ? T_MAX_A : T_MAX_C;
  localparam int CNT_W   = $clog2(T_MAX + 1);

  localparam logic [8:0] CMD_SLPOUT = 9'h011;

  typedef enum logic [3:0] {
    IDLE, RST_LO, RST_WAIT, RD0, RD1, WR_LO, WR_HI, SLP, DONE
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [6:0]       idx;
  logic             idx_clr, idx_inc, capture;
  logic             idx_last;

  assign idx_last = (idx == 7'(ROM_LAST));

  always_comb begin
    state_next = state;
    idx_clr    = 1'b0;
    idx_inc    = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_next = RST_LO;
          idx_clr    = 1'b1;
        end
      end
      RST_LO:   if (cnt == CNT_W'(T_RST_LO - 1))   state_next = RST_WAIT;
      RST_WAIT: if (cnt == CNT_W'(T_RST_WAIT - 1)) state_next = RD0;
      RD0:      state_next = RD1;
      RD1: begin
        capture    = 1'b1;
        state_next = WR_LO;
      end
      WR_LO:    if (cnt == CNT_W'(T_WR_LO - 1))    state_next = WR_HI;
      WR_HI: begin
        if (cnt == CNT_W'(T_WR_HI - 1)) begin
          // Only a command 0x11 (DCX=0) is sleep-out; a 0x11 parameter is ordinary data.
          if ({lcd_dcx, lcd_db} == CMD_SLPOUT) begin
            state_next = SLP;
          end else if (idx_last) begin
            state_next = DONE;
          end else begin
            idx_inc    = 1'b1;
            state_next = RD0;
          end
        end
      end
      SLP: begin
        if (cnt == CNT_W'(T_SLP - 1)) begin
          if (idx_last) begin
            state_next = DONE;
          end else begin
            idx_inc    = 1'b1;
            state_next = RD0;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Dwell counter restarts from zero on every state change.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      lcd_dcx <= 1'b1;
      lcd_db  <= 8'h00;
    end else begin
      state <= state_next;
      cnt   <= (state_next != state) ? '0 : cnt + 1'b1;
      if (idx_clr)      idx <= '0;
      else if (idx_inc) idx <= idx + 1'b1;
      if (capture) begin
        lcd_dcx <= rom_data[8];
        lcd_db  <= rom_data[7:0];
      end
    end
  end

  assign rom_addr  = idx;
  assign lcd_rst_n = (state != RST_LO);
  assign lcd_wr_n  = (state != WR_LO);
  assign lcd_rd_n  = 1'b1;
  assign lcd_cs_n  = (state == IDLE) || (state == RST_LO) || (state == RST_WAIT);
  assign busy      = (state != IDLE) && (state != DONE);
  assign done      = (state == DONE);

endmodule
